// File: rtl/sync_fifo_prog_if.sv
// Handshake/status bundle for sync_fifo_prog.
//   master modport: producer/consumer side (drives clr, writes, reads, thresholds).
//   slave modport : FIFO side (drives rd_data, count, flags, error pulses).
// Signals:
//   clr           synchronous flush
//   wr_enb/wr_data  write request and data
//   rd_enb/rd_data  read request and data
//   afull_thresh/aempty_thresh  runtime almost-full / almost-empty thresholds
//   count         occupancy 0..DEPTH
//   full/empty/half/almost_full/almost_empty  status flags
//   overflow/underflow  one-cycle pulses for rejected write/read
interface sync_fifo_prog_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             clr;
  logic             wr_enb;
  logic [WIDTH-1:0] wr_data;
  logic             rd_enb;
  logic [WIDTH-1:0] rd_data;
  logic [CW-1:0]    afull_thresh;
  logic [CW-1:0]    aempty_thresh;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             half;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output clr, wr_enb, wr_data, rd_enb, afull_thresh, aempty_thresh,
    input  rd_data, count, full, empty, half, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  clr, wr_enb, wr_data, rd_enb, afull_thresh, aempty_thresh,
    output rd_data, count, full, empty, half, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count, runtime almost-full/almost-empty thresholds,
// synchronous flush and registered overflow/underflow pulses. DEPTH need not be a power of 2.
// Ports:
//   clk   clock, all logic on posedge
//   rstn  asynchronous active-low reset (clears pointers, count, rd_data, pulses)
//   bus   sync_fifo_prog_if.slave: clr, wr_enb/wr_data, rd_enb/rd_data, thresholds,
//         count, full/empty/half/almost_full/almost_empty, overflow/underflow
// Configuration:
//   FIFO_FWFT_EN defined   -> first-word fall-through: rd_data shows the head combinationally.
//   FIFO_FWFT_EN undefined -> registered read data, one cycle after an accepted read.
module sync_fifo_prog #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input logic              clk,
  input logic              rstn,
  sync_fifo_prog_if.slave  bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, underflow_q;
  logic             full_w, empty_w, wr_acc, rd_acc;

  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);
  assign rd_acc  = bus.rd_enb & ~empty_w;
  // A read in the same cycle frees a slot, so a full FIFO can still take a write.
  assign wr_acc  = bus.wr_enb & (~full_w | rd_acc);

  // Explicit wrap keeps non-power-of-2 depths correct.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    count_d = count_q;
    if (bus.clr) begin
      count_d = '0;
    end else begin
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (bus.clr) begin
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end else begin
        if (wr_acc) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (rd_acc) rd_ptr_q <= ptr_inc(rd_ptr_q);
        overflow_q  <= bus.wr_enb & ~wr_acc;
        underflow_q <= bus.rd_enb & ~rd_acc;
      end
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !bus.clr) mem[wr_ptr_q] <= bus.wr_data;
  end

`ifdef FIFO_FWFT_EN
  assign bus.rd_data = mem[rd_ptr_q];
`else
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data_q <= '0;
    end else if (rd_acc && !bus.clr) begin
      rd_data_q <= mem[rd_ptr_q];
    end
  end

  assign bus.rd_data = rd_data_q;
`endif

  assign bus.count        = count_q;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.half         = (count_q >= CW'(DEPTH / 2));
  assign bus.almost_full  = (count_q >= bus.afull_thresh);
  assign bus.almost_empty = (count_q <= bus.aempty_thresh);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule
